// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART.
// Holds the register map, STATUS bit positions, the state type used by both
// the TX and RX state machines, and the minimum divisor with its clamp helper.
package uart_pkg;

    localparam logic [1:0] UART_DATA_ADDR   = 2'b00;
    localparam logic [1:0] UART_STATUS_ADDR = 2'b01;
    localparam logic [1:0] UART_DIV_ADDR    = 2'b10;
    localparam logic [1:0] UART_IRQEN_ADDR  = 2'b11;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_VALID   = 1;
    localparam int STAT_TX_DONE    = 2;
    localparam int STAT_RX_OVERRUN = 3;
    localparam int STAT_FRAME_ERR  = 4;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // Divisors below the minimum would leave no room for a mid-bit sample.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver.
// Ports:
//   clk, rst        - system clock, asynchronous active-low reset
//   rx              - asynchronous serial input
//   div             - current baud divisor (clk cycles per bit), latched per frame
//   byte_out        - received byte, valid while byte_valid is high
//   byte_valid      - one-cycle pulse when a frame's stop bit is sampled
//   frame_err       - one-cycle pulse, coincident with byte_valid, stop bit low
//
// state   | meaning
// IDLE    | waiting for a falling edge on the synchronised line
// START   | counting to the middle of the start bit, rejecting glitches
// DATA    | sampling 8 data bits, LSB first
// STOP    | sampling the stop bit, then handing the byte out
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [15:0] div,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        frame_err
);

    logic        rx_meta;
    logic        rx_sync;
    uart_state_t state;
    logic [15:0] cnt;
    logic [15:0] div_lat;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        tick;

    assign tick = (cnt == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            div_lat <= DIV_MIN;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Falling edge about to leave the synchroniser: acting on it
                    // now keeps the start-detect latency at two flops.
                    if (rx_sync && !rx_meta) begin
                        state   <= ST_START;
                        div_lat <= div;
                        cnt     <= {1'b0, div[15:1]} - 16'd1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_sync) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= div_lat - 16'd1;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift <= {rx_sync, shift[7:1]};
                        cnt   <= div_lat - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign byte_out   = shift;
    assign byte_valid = (state == ST_STOP) && tick;
    assign frame_err  = byte_valid && !rx_sync;

endmodule

// File: rtl/uart_port.sv
// uart_port: memory-mapped 8N1 UART transceiver for the peripheral bus.
// Ports:
//   clk, rst   - system clock, asynchronous active-low reset
//   data_in    - CPU write data
//   data_out   - combinational read data for address (0 when ce is low)
//   address    - register select: DATA, STATUS, DIV, IRQEN
//   rw         - 1 = write, 0 = read
//   ce         - chip enable from the address decoder
//   irq        - registered level interrupt
//   tx         - serial output, idle high
//   rx         - asynchronous serial input
//
// state   | meaning
// IDLE    | line high, waiting for a DATA write
// START   | driving the start bit for one divisor period
// DATA    | driving 8 data bits, LSB first
// STOP    | driving the stop bit; tx_done is raised when it ends
module uart_port
    import uart_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] DIV_RESET  = 16'd217
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [1:0]            address,
    input  logic                  rw,
    input  logic                  ce,
    output logic                  irq,
    output logic                  tx,
    input  logic                  rx
);

    logic [15:0] div_reg;
    logic [2:0]  irqen;
    logic        tx_done;
    logic        rx_valid;
    logic        rx_overrun;
    logic        frame_err;
    logic [7:0]  rx_byte;

    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [15:0] tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_busy;

    logic [7:0]  rx_byte_new;
    logic        rx_byte_valid;
    logic        rx_frame_err;

    logic data_wr, data_rd, stat_wr, div_wr, irqen_wr;
    logic tx_start, tx_finish;
    logic unused_data_in;

    assign unused_data_in = ^data_in[DATA_WIDTH-1:16];

    assign data_wr  = ce &  rw && (address == UART_DATA_ADDR);
    assign data_rd  = ce & ~rw && (address == UART_DATA_ADDR);
    assign stat_wr  = ce &  rw && (address == UART_STATUS_ADDR);
    assign div_wr   = ce &  rw && (address == UART_DIV_ADDR);
    assign irqen_wr = ce &  rw && (address == UART_IRQEN_ADDR);

    assign tx_busy   = (tx_state != ST_IDLE);
    assign tx_start  = data_wr && !tx_busy;
    assign tx_finish = (tx_state == ST_STOP) && (tx_cnt == 16'd0);

    uart_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .div        (div_reg),
        .byte_out   (rx_byte_new),
        .byte_valid (rx_byte_valid),
        .frame_err  (rx_frame_err)
    );

    // tx is the state one cycle late, so the line falls on the edge after the
    // accepting write while each bit still lasts exactly one divisor period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx <= (tx_state == ST_START) ? 1'b0 :
                  (tx_state == ST_DATA)  ? tx_shift[0] : 1'b1;
            case (tx_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        tx_state <= ST_START;
                        tx_shift <= data_in[7:0];
                        tx_div   <= div_reg;
                        tx_cnt   <= div_reg - 16'd1;
                    end
                end
                ST_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= tx_div - 16'd1;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt   <= tx_div - 16'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // Flag updates: a set event always takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg    <= DIV_RESET;
            irqen      <= '0;
            tx_done    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_byte    <= '0;
            irq        <= 1'b0;
        end else begin
            if (div_wr) begin
                div_reg <= clamp_div(data_in[15:0]);
            end
            if (irqen_wr) begin
                irqen <= data_in[2:0];
            end

            if (tx_finish) begin
                tx_done <= 1'b1;
            end else if (tx_start || (stat_wr && data_in[STAT_TX_DONE])) begin
                tx_done <= 1'b0;
            end

            if (rx_byte_valid) begin
                rx_valid <= 1'b1;
                rx_byte  <= rx_byte_new;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end

            if (rx_byte_valid && rx_valid) begin
                rx_overrun <= 1'b1;
            end else if (stat_wr && data_in[STAT_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end

            if (rx_frame_err) begin
                frame_err <= 1'b1;
            end else if (stat_wr && data_in[STAT_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end

            irq <= (irqen[0] & tx_done) | (irqen[1] & rx_valid) |
                   (irqen[2] & (rx_overrun | frame_err));
        end
    end

    always_comb begin
        data_out = '0;
        if (ce) begin
            case (address)
                UART_DATA_ADDR:   data_out[7:0] = rx_byte;
                UART_STATUS_ADDR: begin
                    data_out[STAT_TX_BUSY]    = tx_busy;
                    data_out[STAT_RX_VALID]   = rx_valid;
                    data_out[STAT_TX_DONE]    = tx_done;
                    data_out[STAT_RX_OVERRUN] = rx_overrun;
                    data_out[STAT_FRAME_ERR]  = frame_err;
                end
                UART_DIV_ADDR:    data_out[15:0] = div_reg;
                default:          data_out[2:0] = irqen;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_port.sv
module tb_uart_port;

    localparam logic [1:0] A_DATA   = 2'b00;
    localparam logic [1:0] A_STATUS = 2'b01;
    localparam logic [1:0] A_DIV    = 2'b10;
    localparam logic [1:0] A_IRQEN  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        rw = 1'b0;
    logic        rx = 1'b1;
    logic [1:0]  address = 2'b00;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        irq;
    logic        tx;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model of the programmer-visible state
    int       div_m = 217;
    bit [2:0] irqen_m = '0;
    bit       done_m, valid_m, ovr_m, ferr_m;
    bit [7:0] byte_m;

    uart_port #(.DATA_WIDTH(32), .DIV_RESET(16'd217)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .address  (address),
        .rw       (rw),
        .ce       (ce),
        .irq      (irq),
        .tx       (tx),
        .rx       (rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = '0;
        s[1] = valid_m; s[2] = done_m; s[3] = ovr_m; s[4] = ferr_m;
        return s;
    endfunction

    function automatic logic irq_m();
        return (irqen_m[0] & done_m) | (irqen_m[1] & valid_m) | (irqen_m[2] & (ovr_m | ferr_m));
    endfunction

    function automatic int clamp_m(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // All bus tasks are entered just after a falling clock edge and return just after one.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        ce = 1'b1; rw = 1'b1; address = a; data_in = d;
        @(negedge clk);
        ce = 1'b0; rw = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        ce = 1'b1; rw = 1'b0; address = a;
        #1 d = data_out;
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic reset_model();
        div_m = 217; irqen_m = '0;
        done_m = 0; valid_m = 0; ovr_m = 0; ferr_m = 0; byte_m = '0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(A_STATUS, d);
        check(tag, d, status_m());
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, irq_m()});
    endtask

    task automatic read_byte(input string tag);
        logic [31:0] d;
        bus_read(A_DATA, d);
        check(tag, d, {24'b0, byte_m});
        valid_m = 0;
    endtask

    // op: 0 none, 1 DATA write while busy, 2 DIV write mid-frame, 3 W1C tx_done on the finishing edge
    task automatic tx_frame(input logic [7:0] b, input int tail, input int op, input int opval);
        int div, last, j;
        logic [9:0] fr;
        logic [31:0] e;
        logic ei;
        div  = div_m;
        last = 10 * div;
        fr   = {1'b1, b, 1'b0};
        j    = (op == 3) ? last - 1 : $urandom_range(last - 3, 2);
        bus_write(A_DATA, {24'b0, b});
        check("tx_idle_after_accept", {31'b0, tx}, 32'd1);
        check("irq_at_accept", {31'b0, irq}, {31'b0, irq_m()});
        done_m = 0;
        ce = 1'b1; rw = 1'b0; address = A_STATUS;
        for (int k = 1; k <= last + tail; k++) begin
            @(negedge clk);
            check("tx_bit", {31'b0, tx}, (k <= last) ? {31'b0, fr[(k - 1) / div]} : 32'd1);
            if (op == 0 || k != j + 1) begin
                e = '0;
                e[0] = (k < last); e[1] = valid_m; e[2] = (k >= last); e[3] = ovr_m; e[4] = ferr_m;
                check("tx_status", data_out, e);
            end
            ei = (irqen_m[0] && (k - 1 >= last)) || (irqen_m[1] && valid_m) ||
                 (irqen_m[2] && (ovr_m || ferr_m));
            check("tx_irq", {31'b0, irq}, {31'b0, ei});
            if (op != 0 && k == j) begin
                rw = 1'b1;
                case (op)
                    1: begin address = A_DATA;   data_in = 32'h11; end
                    2: begin address = A_DIV;    data_in = opval; end
                    default: begin address = A_STATUS; data_in = 32'h4; end
                endcase
            end else if (k == j + 1) begin
                rw = 1'b0; address = A_STATUS;
            end
        end
        ce = 1'b0; rw = 1'b0;
        done_m = 1;
        if (op == 2) div_m = clamp_m(opval);
    endtask

    // Drives one frame on rx and watches rx_valid each cycle. With rd_race a DATA read
    // is placed on the very edge the new byte completes.
    task automatic rx_send(input logic [7:0] b, input bit stop_ok, input bit rd_race);
        int div, lat, tot;
        logic [9:0] fr;
        bit vb;
        div = div_m;
        lat = 2 + div / 2 + 9 * div;
        tot = 10 * div + 2;
        fr  = {stop_ok, b, 1'b0};
        vb  = valid_m;
        ce = 1'b1; rw = 1'b0; address = A_STATUS;
        for (int n = 0; n <= tot; n++) begin
            if (n > 0 && !(rd_race && n == lat))
                check("rx_valid_timing", {31'b0, data_out[1]}, {31'b0, vb || (n >= lat)});
            rx = (n < 10 * div) ? fr[n / div] : 1'b1;
            if (rd_race && n == lat - 1) address = A_DATA;
            else if (rd_race && n == lat) address = A_STATUS;
            @(negedge clk);
        end
        ce = 1'b0;
        ovr_m   = ovr_m | valid_m;
        valid_m = 1;
        byte_m  = b;
        if (!stop_ok) ferr_m = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int op, tail;

        reset_model();
        #2 rst = 1'b0;
        #5;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_data_out_ce0", data_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        bus_read(A_STATUS, d); check("reset_status", d, 32'h0);
        bus_read(A_DIV, d);    check("reset_div", d, 32'd217);
        bus_read(A_IRQEN, d);  check("reset_irqen", d, 32'h0);

        bus_write(A_DIV, 32'd0);          bus_read(A_DIV, d); check("div_clamp0", d, 32'd2);
        bus_write(A_DIV, 32'd1);          bus_read(A_DIV, d); check("div_clamp1", d, 32'd2);
        bus_write(A_DIV, 32'hABCD_1234);  bus_read(A_DIV, d); check("div_zext", d, 32'h1234);

        bus_write(A_DIV, 32'd4);   div_m = 4;
        bus_write(A_IRQEN, 32'd1); irqen_m = 3'b001;
        tx_frame(8'hA5, 2, 1, 0);

        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom);
            op = $urandom_range(0, 3);
            tail = (op == 3) ? 2 : 2 * $urandom_range(0, 1);
            tx_frame(b, tail, op, $urandom_range(4, 9));
        end
        bus_write(A_STATUS, 32'h4); done_m = 0;
        @(negedge clk);
        check_status("tx_done_w1c");

        // reset in the middle of a frame
        bus_write(A_DIV, 32'd8);
        bus_write(A_DATA, 32'h5A);
        @(negedge clk);
        check("tx_start_bit", {31'b0, tx}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_tx", {31'b0, tx}, 32'd1);
        check("rst_mid_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        check_status("status_after_rst");
        bus_read(A_DIV, d); check("div_after_rst", d, 32'd217);
        check("tx_after_rst", {31'b0, tx}, 32'd1);

        // receive path
        bus_write(A_DIV, 32'd8);   div_m = 8;
        bus_write(A_IRQEN, 32'd6); irqen_m = 3'b110;
        rx_send(8'h3C, 1, 0);
        check_status("rx_3c_status");
        read_byte("rx_3c_data");
        @(negedge clk);
        check_status("rx_cleared");

        for (int i = 0; i < 3; i++) begin
            div_m = $urandom_range(4, 10);
            bus_write(A_DIV, div_m);
            rx_send(8'($urandom), 1, 0);
            check_status("rx_rand_status");
            read_byte("rx_rand_data");
        end

        bus_write(A_DIV, 32'd8); div_m = 8;
        rx_send(8'($urandom), 1, 0);
        rx_send(8'($urandom), 1, 0);
        check_status("rx_overrun_status");
        read_byte("rx_overrun_data");
        bus_write(A_STATUS, 32'h8); ovr_m = 0;
        @(negedge clk);
        check_status("rx_overrun_w1c");

        rx_send(8'($urandom), 1, 0);
        rx_send(8'($urandom), 1, 1);
        check_status("rx_read_race_status");
        read_byte("rx_read_race_data");
        bus_write(A_STATUS, 32'h8); ovr_m = 0;

        rx_send(8'($urandom), 0, 0);
        check_status("rx_frame_err_status");
        read_byte("rx_frame_err_data");
        bus_write(A_STATUS, 32'h10); ferr_m = 0;
        @(negedge clk);
        check_status("rx_frame_err_w1c");

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check_status("rx_glitch_status");
        read_byte("rx_glitch_data");

        rx_send(8'($urandom), 1, 0);
        check_status("rx_final_status");
        read_byte("rx_final_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
